// File: rtl/elbeth_mem_pkg.sv
// Shared definitions for the elbeth memory path: FSM state encodings,
// error-cause codes (also used by the elbeth_memory_bridge exception logic),
// the read byte-enable constant and the requester identifiers.
package elbeth_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_MEM     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [3:0] RW_READ = 4'b0000;

endpackage

// File: rtl/elbeth_memory_arbiter_if.sv
// Single elbeth memory port.
//   master : arbiter side, drives en/addr/wdata/rw, receives rdata/ready/error
//   slave  : memory side
interface elbeth_memory_arbiter_if #(
    parameter int MEM_AW = 8,
    parameter int DW     = 32
);
    logic              en;
    logic [MEM_AW-1:0] addr;
    logic [DW-1:0]     wdata;
    logic [3:0]        rw;
    logic [DW-1:0]     rdata;
    logic              ready;
    logic              error;

    modport master (output en, addr, wdata, rw, input rdata, ready, error);
    modport slave  (input en, addr, wdata, rw, output rdata, ready, error);
endinterface

// File: rtl/elbeth_rr_arbiter2.sv
// Two-way round-robin grant between instruction (I) and data (D) requesters.
//   clk, rst : clock, synchronous active-high reset (last grant returns to I)
//   req_i    : instruction request
//   req_d    : data request
//   update   : record the current grant as the last grant
//   gnt      : combinational grant, valid when either request is set
module elbeth_rr_arbiter2
    import elbeth_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output gnt_e gnt
);

    gnt_e last_grant_q;
    gnt_e last_grant_d;

    // D wins when it is the sole requester, or on contention when I went last.
    always_comb begin
        gnt = GNT_I;
        if (req_d && (!req_i || last_grant_q == GNT_I)) begin
            gnt = GNT_D;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/elbeth_memory_arbiter.sv
// Shares one elbeth memory port between instruction fetch (I) and data
// access (D): grant, word-address translation, range check, access timeout
// and response routing.
//   clk, rst            : clock, synchronous active-high reset
//   i_en/i_addr         : instruction request, response on i_rdata/i_ready/i_error
//   d_en/d_addr/d_wdata/d_rw : data request, response on d_rdata/d_ready/d_error
//   err_src             : cause of the current error pulse
//   mem                 : memory port (master side)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no access; arbitrate and latch the granted request
// ST_ACCESS  | mem_en high, waiting for mem_ready/mem_error or timeout
// ST_RESPOND | one-cycle ready/error pulse to the granted requester
module elbeth_memory_arbiter
    import elbeth_mem_pkg::*;
#(
    parameter int MEM_AW  = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_en,
    input  logic [31:0]       i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_ready,
    output logic              i_error,

    input  logic              d_en,
    input  logic [31:0]       d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [3:0]        d_rw,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ready,
    output logic              d_error,

    output logic [1:0]        err_src,

    elbeth_memory_arbiter_if.master mem
);

    localparam int         CW      = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    gnt_e              sel_q, sel_d;
    logic              mem_en_q, mem_en_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_rw_q, mem_rw_d;
    logic              i_ready_q, i_ready_d;
    logic              i_error_q, i_error_d;
    logic              d_ready_q, d_ready_d;
    logic              d_error_q, d_error_d;
    logic [1:0]        err_src_q, err_src_d;
    logic [DW-1:0]     i_rdata_q, i_rdata_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;

    gnt_e              arb_gnt;
    logic              arb_update;
    logic [31:0]       req_addr;
    logic [DW-1:0]     req_wdata;
    logic [3:0]        req_rw;
    logic              req_out_of_range;
    logic              resp_ok;
    logic              resp_err;
    gnt_e              resp_sel;
    logic              unused_addr_lsb;

    elbeth_rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  (i_en),
        .req_d  (d_en),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // Request as seen through the grant; instruction fetches are always reads.
    always_comb begin
        req_addr  = i_addr;
        req_wdata = '0;
        req_rw    = RW_READ;
        if (arb_gnt == GNT_D) begin
            req_addr  = d_addr;
            req_wdata = d_wdata;
            req_rw    = d_rw;
        end
    end

    assign req_out_of_range = (req_addr[31:MEM_AW+2] != '0);
    // Byte-in-word bits are not used; alignment is handled upstream.
    assign unused_addr_lsb  = ^req_addr[1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_d    = mem_rw_q;
        err_src_d   = ERR_NONE;
        arb_update  = 1'b0;
        resp_ok     = 1'b0;
        resp_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_en || d_en) begin
                    arb_update  = 1'b1;
                    sel_d       = arb_gnt;
                    mem_addr_d  = req_addr[MEM_AW+1:2];
                    mem_wdata_d = req_wdata;
                    mem_rw_d    = req_rw;
                    cnt_d       = '0;
                    if (req_out_of_range) begin
                        state_d   = ST_RESPOND;
                        err_src_d = ERR_RANGE;
                        resp_err  = 1'b1;
                    end else begin
                        state_d  = ST_ACCESS;
                        mem_en_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem.error) begin
                    state_d   = ST_RESPOND;
                    err_src_d = ERR_MEM;
                    resp_err  = 1'b1;
                end else if (mem.ready) begin
                    state_d = ST_RESPOND;
                    resp_ok = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_RESPOND;
                    err_src_d = ERR_TIMEOUT;
                    resp_err  = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // The pulse is registered on the same edge as the move into RESPOND, so
    // it is visible exactly during the RESPOND cycle.
    assign resp_sel = (state_q == ST_IDLE) ? arb_gnt : sel_q;

    always_comb begin
        i_ready_d = 1'b0;
        i_error_d = 1'b0;
        d_ready_d = 1'b0;
        d_error_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (resp_sel == GNT_D) begin
            d_error_d = resp_err;
            d_ready_d = resp_ok;
            if (resp_ok) begin
                d_rdata_d = mem.rdata;
            end
        end else begin
            i_error_d = resp_err;
            i_ready_d = resp_ok;
            if (resp_ok) begin
                i_rdata_d = mem.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= GNT_I;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= '0;
            i_ready_q   <= 1'b0;
            i_error_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            d_error_q   <= 1'b0;
            err_src_q   <= ERR_NONE;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rw_q    <= mem_rw_d;
            i_ready_q   <= i_ready_d;
            i_error_q   <= i_error_d;
            d_ready_q   <= d_ready_d;
            d_error_q   <= d_error_d;
            err_src_q   <= err_src_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem.en    = mem_en_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign mem.rw    = mem_rw_q;
    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign i_error   = i_error_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_error   = d_error_q;
    assign err_src   = err_src_q;

endmodule

// File: doc/elbeth_memory_arbiter.md
Name: elbeth_memory_arbiter

Overview:
Shares one elbeth_memory port (en/addr/in_data/rw/out_data/ready/error) between two processor requesters: instruction fetch (requester I) and data access (requester D). It sits between the CPU-side request interfaces and a single memory port, so a single-port memory can replace the dual-port arrangement. It owns grant, address translation, range checking, access timeout and response routing.

Parameters:
MEM_AW, 8, memory word-address width; byte address bits [MEM_AW+1:2] select the word.
DW, 32, data width.
TIMEOUT, 16, maximum cycles in ACCESS waiting for mem_ready before the access is aborted (legal range 2..255).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_en  in  1  instruction request; held until i_ready or i_error
i_addr  in  32  instruction byte address
i_rdata  out  DW  fetched instruction; valid when i_ready=1
i_ready  out  1  one-cycle completion pulse
i_error  out  1  one-cycle error pulse (mutually exclusive with i_ready)
d_en  in  1  data request; held until d_ready or d_error
d_addr  in  32  data byte address
d_wdata  in  DW  write data
d_rw  in  4  byte write enables; 4'b0000 = read
d_rdata  out  DW  read data; valid when d_ready=1
d_ready  out  1  one-cycle completion pulse
d_error  out  1  one-cycle error pulse
err_src  out  2  error cause, valid with any error pulse: 01 out-of-range, 10 mem_error, 11 timeout
mem_en  out  1  memory enable
mem_addr  out  MEM_AW  word address
mem_wdata  out  DW  write data to memory
mem_rw  out  4  byte enables to memory
mem_rdata  in  DW  memory read data
mem_ready  in  1  memory completion
mem_error  in  1  memory error

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. While rst=1, every output is 0, the FSM is in IDLE, the timeout counter is 0 and last_grant is I.
- FSM states: IDLE, ACCESS, RESPOND. All outputs are registered.
- IDLE:
  - No request: stay in IDLE with mem_en=0.
  - One request: grant that requester.
  - Both requesting: grant the requester not in last_grant (round-robin), then update last_grant.
  - The granted request's addr, wdata and rw are latched. Requester I always drives rw=0000.
  - Range check: if granted addr[31:MEM_AW+2] is not 0, go to RESPOND with err_src=01. No memory cycle is issued.
  - Otherwise go to ACCESS with mem_addr=addr[MEM_AW+1:2]. Low address bits [1:0] are ignored; alignment is checked upstream.
- ACCESS:
  - mem_en=1; mem_addr, mem_wdata and mem_rw are held stable.
  - The counter increments each cycle.
  - mem_error=1 takes priority: go to RESPOND with err_src=10.
  - Else mem_ready=1: latch mem_rdata and go to RESPOND as a success.
  - Else counter==TIMEOUT-1: go to RESPOND with err_src=11.
- RESPOND:
  - mem_en=0.
  - Pulse exactly one of ready/error on the granted requester for 1 cycle; *_rdata holds its value until the next response to that requester.
  - err_src=00 on success. Clear the counter and return to IDLE.
- Latency: a request seen in IDLE at edge k drives mem_en=1 from edge k+1. mem_ready sampled at edge k+1+n gives a ready pulse in the cycle after edge k+1+n. Minimum round trip is 3 cycles.
- Back-to-back: there is always one IDLE cycle between accesses, so mem_en drops for at least 2 cycles between accesses.
- A requester's en is ignored while the other requester is being served. A requester dropping en mid-access does not abort the access; the response is still pulsed.
- rst asserted during ACCESS aborts the access with no response pulse. mem_en is 0 in the cycle after the reset edge.
- A mem_ready or mem_error arriving outside ACCESS is ignored.

Decomposition:
- Shared package elbeth_mem_pkg holds:
  - FSM state encodings;
  - err_src codes (ERR_NONE=00, ERR_RANGE=01, ERR_MEM=10, ERR_TIMEOUT=11);
  - the RW_READ=4'b0000 constant.
  The elbeth_memory_bridge exception logic reuses the same codes.
- One natural sub-module: elbeth_rr_arbiter2, a 2-way round-robin grant with last_grant register and update strobe, on clk/rst.
- The FSM, counter and response muxing stay in the top module.

Test Plan:
- Reset mid-access: d_en=1 with d_addr=0x8, memory stalled; assert rst in ACCESS -> no d_ready or d_error pulse; mem_en=0 in the cycle after the reset edge; all outputs 0 during reset.
- Single read: i_en=1 with i_addr=0x8, memory returns 0xDEADBEEF with mem_ready one cycle after mem_en -> mem_addr=8'h02, mem_rw=0000, i_ready pulses once with i_rdata=0xDEADBEEF, d_ready stays 0.
- Contention: i_en=1 and d_en=1 from reset (last_grant=I); d_addr=0x11C, d_rw=1111, d_wdata=0xFFFFFFBA -> D is served first (mem_addr=8'h47, mem_wdata=0xFFFFFFBA), then I, then D again if both are still requesting.
- Out of range: d_addr=0x400 -> no mem_en assertion; d_error pulses with err_src=01 two cycles after d_en is seen.
- Timeout: TIMEOUT=16, memory never raises mem_ready -> mem_en stays high for exactly 16 cycles, then i_error pulses with err_src=11; the next request is served normally.
- Memory error: mem_error=1 and mem_ready=1 in the same cycle -> d_error with err_src=10 and no d_ready pulse.
